// File: rtl/fsm_pkg.sv
// Shared FSM state encoding and default pattern for the serial pattern generator.
// GUARD is always encoded; it is only reachable when SEQ_PATTERN_GEN_PAD_EN is defined.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GUARD = 2'd3
  } state_t;

  localparam logic [3:0] PATTERN_DEFAULT = 4'b1001;

endpackage

// File: rtl/seq_pattern_gen_shift_rot.sv
// Parallel-load, rotate-left register exposing its MSB.
// Rotation (not shift) keeps the pattern intact for repeated transmission.
module seq_shift_rot #(
  parameter int              W       = 4,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_rot,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_rot) begin
      r_q <= {r_q[W-2:0], r_q[W-1]};
    end
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: latches a pattern and repeat count on start, shifts MSB-first.
// Build option SEQ_PATTERN_GEN_PAD_EN inserts a one-cycle zero guard bit between repetitions.
module seq_pattern_gen
  import fsm_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PATTERN_RST = PAT_W'(PATTERN_DEFAULT),
  parameter int               CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int             BW       = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(PAT_W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_rep;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_msb;

  // Start is only honoured in IDLE; every other state ignores it.
  assign w_accept   = (r_state == IDLE) && start;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  seq_shift_rot #(
    .W       (PAT_W),
    .RST_VAL (PATTERN_RST)
  ) u_shift_rot (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_data (pattern_in),
    .i_rot  (r_state == SHIFT),
    .o_msb  (w_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_rep     <= '0;
    end else if (w_accept) begin
      r_bit_cnt <= '0;
      r_rep     <= repeat_n;
    end else if (r_state == SHIFT) begin
      if (w_last_bit) begin
        r_bit_cnt <= '0;
        r_rep     <= r_rep - CNT_W'(1);
      end else begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (repeat_n == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_bit) begin
          if (r_rep == CNT_W'(1)) begin
            w_next = DONE;
          end else begin
`ifdef SEQ_PATTERN_GEN_PAD_EN
            w_next = GUARD;
`else
            w_next = SHIFT;
`endif
          end
        end
      end
      DONE:    w_next = IDLE;
`ifdef SEQ_PATTERN_GEN_PAD_EN
      GUARD:   w_next = SHIFT;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    out   = 1'b0;
    valid = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (r_state)
      IDLE:  busy = 1'b0;
      SHIFT: begin
        valid = 1'b1;
        out   = w_msb;
      end
      DONE:  done = 1'b1;
`ifdef SEQ_PATTERN_GEN_PAD_EN
      GUARD: valid = 1'b1;
`endif
      default: ;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed table, hand-written corner sequences
// and randomized bursts compared against a stream model built from the pattern rules.
module tb_seq_pattern_gen;
  import fsm_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic             out, valid, busy, done;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];

  typedef struct {
    string       name;
    logic [3:0]  pat;
    logic [3:0]  n;
    logic [31:0] bits;
    int          len;
    int          inject;
  } vec_t;

  vec_t vecs[6];

  seq_pattern_gen #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern_in (pattern_in),
    .repeat_n   (repeat_n),
    .out        (out),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: each repetition sends the pattern MSB first; with padding a zero
  // guard bit (still valid) separates repetitions.
  task automatic model_fill(input logic [3:0] pat, input logic [3:0] n);
    exp_q.delete();
    for (int r = 0; r < int'(n); r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back(pat[i]);
`ifdef SEQ_PATTERN_GEN_PAD_EN
      if (r < int'(n) - 1) exp_q.push_back(1'b0);
`endif
    end
  endtask

  task automatic table_fill(input logic [31:0] bits, input int len);
    exp_q.delete();
    for (int i = len - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  // Called at a negedge; returns at the negedge of cycle k+1 with start released.
  task automatic send_start(input logic [3:0] pat, input logic [3:0] n);
    start      = 1'b1;
    pattern_in = pat;
    repeat_n   = n;
    @(negedge clk);
    start      = 1'b0;
    pattern_in = 4'($urandom_range(0, 15));
    repeat_n   = 4'($urandom_range(0, 15));
  endtask

  task automatic check_burst(input string name, input int inject);
    int c;
    logic [0:0] b;
    c = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      chk({name, ".valid"}, 32'(valid), 32'd1);
      chk({name, ".out"},   32'(out),   32'(b));
      chk({name, ".busy"},  32'(busy),  32'd1);
      chk({name, ".done"},  32'(done),  32'd0);
      if (c == inject) begin
        start      = 1'b1;
        pattern_in = 4'hF;
        repeat_n   = 4'd3;
      end
      @(negedge clk);
      start = 1'b0;
      c++;
    end
    chk({name, ".done_pulse"}, 32'(done),  32'd1);
    chk({name, ".done_busy"},  32'(busy),  32'd1);
    chk({name, ".done_valid"}, 32'(valid), 32'd0);
    chk({name, ".done_out"},   32'(out),   32'd0);
    if (c == inject) begin
      start      = 1'b1;
      pattern_in = 4'hF;
      repeat_n   = 4'd3;
    end
    @(negedge clk);
    start = 1'b0;
    chk({name, ".idle_busy"},  32'(busy),      32'd0);
    chk({name, ".idle_done"},  32'(done),      32'd0);
    chk({name, ".idle_valid"}, 32'(valid),     32'd0);
    chk({name, ".idle_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    vecs[0] = '{name: "t1_1001x1", pat: 4'b1001, n: 4'd1, bits: 32'b1001, len: 4, inject: -1};
`ifdef SEQ_PATTERN_GEN_PAD_EN
    vecs[1] = '{name: "t6_1001x2", pat: 4'b1001, n: 4'd2, bits: 32'b100101001, len: 9, inject: -1};
    vecs[4] = '{name: "t_1010x3", pat: 4'b1010, n: 4'd3, bits: 32'b10100101001010, len: 14, inject: -1};
`else
    vecs[1] = '{name: "t2_1001x2", pat: 4'b1001, n: 4'd2, bits: 32'b10011001, len: 8, inject: -1};
    vecs[4] = '{name: "t_1010x3", pat: 4'b1010, n: 4'd3, bits: 32'b101010101010, len: 12, inject: -1};
`endif
    vecs[2] = '{name: "t3_zero", pat: 4'b1100, n: 4'd0, bits: 32'b0, len: 0, inject: -1};
    vecs[3] = '{name: "t4_ign_busy", pat: 4'b1001, n: 4'd1, bits: 32'b1001, len: 4, inject: 1};
    vecs[5] = '{name: "t_ign_done", pat: 4'b0011, n: 4'd1, bits: 32'b0011, len: 4, inject: 4};

    // Reset state, observed while reset is still held.
    #12;
    chk("rst_out",   32'(out),       32'd0);
    chk("rst_valid", 32'(valid),     32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      table_fill(vecs[i].bits, vecs[i].len);
      send_start(vecs[i].pat, vecs[i].n);
      check_burst(vecs[i].name, vecs[i].inject);
      @(negedge clk);
    end

    // Asynchronous reset part-way through a three-repeat burst.
    send_start(4'b1001, 4'd3);
    chk("t5_c1_out", 32'(out), 32'd1);
    @(negedge clk);
    chk("t5_c2_out", 32'(out), 32'd0);
    @(negedge clk);
    chk("t5_c3_valid", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out",   32'(out),   32'd0);
    chk("t5_rst_valid", 32'(valid), 32'd0);
    chk("t5_rst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_done", 32'(done), 32'd0);
      chk("t5_no_busy", 32'(busy), 32'd0);
    end
    model_fill(4'b0110, 4'd1);
    send_start(4'b0110, 4'd1);
    check_burst("t5_after", -1);

    // Back-to-back: start again in the first IDLE cycle after DONE.
    model_fill(4'b1101, 4'd2);
    send_start(4'b1101, 4'd2);
    check_burst("b2b_a", -1);
    model_fill(4'b0100, 4'd1);
    send_start(4'b0100, 4'd1);
    check_burst("b2b_b", -1);

    for (int k = 0; k < 30; k++) begin
      logic [3:0] pat;
      logic [3:0] n;
      pat = 4'($urandom_range(0, 15));
      n   = 4'($urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_fill(pat, n);
      send_start(pat, n);
      check_burst("rnd", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
